// File: rtl/f1_reaction_ctrl.sv
// Reaction-time scorer for the F1 starting-lights game: watches the light bar,
// times lights-out to button press in ms ticks, flags jump starts and timeouts.
module f1_reaction_ctrl #(
  parameter int WIDTH        = 16,
  parameter int TIMEOUT_MS   = 2000,
  parameter int MIN_VALID_MS = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lights,
  input  logic             tick,
  input  logic             button,
  input  logic             clear_best,
  output logic [WIDTH-1:0] reaction_ms,
  output logic [WIDTH-1:0] best_ms,
  output logic             result_valid,
  output logic             jump_start,
  output logic             timed_out,
  output logic             busy
);

  localparam logic [WIDTH-1:0] LP_TIMEOUT = WIDTH'(TIMEOUT_MS);
  localparam logic [WIDTH-1:0] LP_MIN     = WIDTH'(MIN_VALID_MS);
  localparam logic [WIDTH-1:0] LP_ONES    = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FULL,
    S_TIMING,
    S_FOUL,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_button_q;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_reaction;
  logic [WIDTH-1:0] r_best;
  logic             r_rv;
  logic             r_js;
  logic             r_to;

  logic             w_press;
  logic [WIDTH-1:0] w_cap;
  logic             w_start;
  logic             w_foul;
  logic             w_capture;
  logic             w_timeout;
  logic             w_cnt_clr;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                               input logic inc);
    if (inc && (v != LP_ONES))
      return v + {{(WIDTH-1){1'b0}}, 1'b1};
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] min_of(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // A press that shares its cycle with a tick includes that tick.
  assign w_press = button & ~r_button_q;
  assign w_cap   = sat_inc(r_cnt, tick);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_foul      = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lights != 8'h00) begin
          w_state_nxt = S_ARMED;
          w_start     = 1'b1;
        end
      end
      S_ARMED: begin
        if (w_press) begin
          w_state_nxt = S_FOUL;
          w_foul      = 1'b1;
        end else if (lights == 8'hFF) begin
          w_state_nxt = S_FULL;
        end else if (lights == 8'h00) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FULL: begin
        if (w_press) begin
          w_state_nxt = S_FOUL;
          w_foul      = 1'b1;
        end else if (lights == 8'h00) begin
          w_state_nxt = S_TIMING;
          w_cnt_clr   = 1'b1;
        end
      end
      S_TIMING: begin
        if (w_press) begin
          if (w_cap < LP_MIN) begin
            w_state_nxt = S_FOUL;
            w_foul      = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_capture   = 1'b1;
          end
        end else if (w_cap >= LP_TIMEOUT) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end
      end
      S_FOUL: w_state_nxt = S_DONE;
      S_DONE: begin
        if ((lights == 8'h00) && !w_press)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_button_q <= 1'b1;
      r_cnt      <= '0;
      r_reaction <= '0;
      r_best     <= LP_ONES;
      r_rv       <= 1'b0;
      r_js       <= 1'b0;
      r_to       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_button_q <= button;
      r_rv       <= w_capture;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_state == S_TIMING)
        r_cnt <= w_cap;
      if (w_capture)
        r_reaction <= w_cap;
      // A capture coinciding with clear_best writes the new time, not all ones.
      if (w_capture)
        r_best <= clear_best ? w_cap : min_of(r_best, w_cap);
      else if (clear_best)
        r_best <= LP_ONES;
      if (w_start) begin
        r_js <= 1'b0;
        r_to <= 1'b0;
      end
      if (w_foul)
        r_js <= 1'b1;
      if (w_timeout)
        r_to <= 1'b1;
    end
  end

  assign reaction_ms  = r_reaction;
  assign best_ms      = r_best;
  assign result_valid = r_rv;
  assign jump_start   = r_js;
  assign timed_out    = r_to;
  assign busy         = (r_state == S_ARMED) || (r_state == S_FULL) ||
                        (r_state == S_TIMING);

endmodule

// File: doc/f1_reaction_ctrl.md
Name: f1_reaction_ctrl

Overview:
- Scores the driver in the F1 starting-lights game.
- Watches the light bar driven by the light-sequence FSM, times the interval from lights-out to the player's button press in 1 ms ticks from the tick generator, and flags jump starts.
- Holds the last and best valid reaction times for the display path.
- Sits beside the light-sequence FSM at top level and does not alter the sequence.

Parameters:
- WIDTH, 16, bit width of all time counters/outputs
- TIMEOUT_MS, 2000, ms after lights-out with no press before attempt is abandoned
- MIN_VALID_MS, 100, presses faster than this after lights-out count as anticipation (foul)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- lights  input  8  light bar from sequence FSM (thermometer code, 8'hFF = all lit)
- tick  input  1  one-cycle pulse every 1 ms
- button  input  1  player button, already synchronised to clk, level
- clear_best  input  1  one-cycle pulse, resets best_ms
- reaction_ms  output  WIDTH  last captured reaction time
- best_ms  output  WIDTH  lowest valid reaction time since reset/clear
- result_valid  output  1  one-cycle pulse when reaction_ms updated with a valid result
- jump_start  output  1  level, set on foul, cleared at next attempt start
- timed_out  output  1  level, set on timeout, cleared at next attempt start
- busy  output  1  high in ARMED, FULL, TIMING

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, reaction_ms=0, best_ms=all ones, result_valid=0, jump_start=0, timed_out=0, busy=0.
- Button edge: press = button & ~button_q. button_q is a registered copy of button, reset to 1, so a button held through reset never makes a press. Only presses act; levels are ignored.
- States:
  - IDLE: lights != 0 -> ARMED, clear jump_start and timed_out.
  - ARMED: lights == 8'hFF -> FULL. Press -> FOUL. lights back to 0 without reaching FF -> IDLE (aborted sequence).
  - FULL: press -> FOUL. lights == 0 -> TIMING, counter=0.
  - TIMING: tick increments counter, saturating at all ones.
    - Press: the captured value is counter plus this cycle's tick if both occur in the same cycle.
    - Captured < MIN_VALID_MS -> FOUL. Otherwise reaction_ms = captured, result_valid=1 for one cycle, best_ms = min(best_ms, captured), -> DONE.
    - Counter reaches TIMEOUT_MS with no press -> timed_out=1, -> DONE. reaction_ms unchanged.
  - FOUL: jump_start=1, -> DONE next cycle. reaction_ms and best_ms unchanged.
  - DONE: wait for lights == 0 and no press in that cycle, then -> IDLE.
- Latency:
  - Lights transition seen in cycle n produces the state change at edge n+1.
  - result_valid is asserted in the cycle after the capturing press.
- Simultaneous events:
  - Press in the same cycle as lights 8'hFF -> 0: counts as FOUL (lights-out not yet registered).
  - Press and TIMEOUT_MS reached in the same cycle: press wins if captured >= MIN_VALID_MS.
- clear_best: sets best_ms to all ones in any state. If coincident with a capture, the new capture is written (capture wins).
- A new lights != 0 while in DONE is ignored until lights have returned to 0.
- Reset asserted mid-attempt returns all state to reset values immediately. best_ms is lost.

Test Plan:
- Normal attempt: lights ramp 01..FF, then 00. Press after 250 ticks -> reaction_ms=250, one result_valid pulse, best_ms=250, jump_start=0.
- Best tracking: second attempt 180 ticks -> best_ms=180. Third attempt 300 -> reaction_ms=300, best_ms stays 180. Pulse clear_best -> best_ms=16'hFFFF.
- Jump start: press while lights=8'h3F -> jump_start=1, no result_valid, reaction_ms unchanged. Next sequence start clears jump_start. Press at 50 ticks after lights-out -> foul.
- Timeout: lights out, no press for 2000 ticks -> timed_out=1, busy=0 after DONE, reaction_ms unchanged.
- Edge cases: button held high from before lights-out -> no capture, eventual timeout. Press coincident with FF->00 -> foul. Press coincident with tick at counter=149 -> reaction_ms=150.
- Async reset mid-TIMING, between clock edges -> all outputs at reset values before the next edge. Next full sequence behaves normally.
